// File: rtl/alu_issue_seq_pkg.sv
// Shared types for the ALU issue/writeback sequencer: opcode and FSM state encodings
// plus the ALU operand-register enable patterns.
package alu_issue_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'd0,
      OP_MAC  = 2'd1,
      OP_LOAD = 2'd2,
      OP_NOP  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   localparam logic [4:0] REG_EN_ALL  = 5'b11111;
   localparam logic [4:0] REG_EN_NONE = 5'b00000;

endpackage

// File: rtl/alu_issue_seq_if.sv
// Instruction-issue and register-file write handshakes of the sequencer.
// The slave modport is the sequencer side; master is the surrounding pipeline.
interface alu_issue_seq_if #(
   parameter int BUS_WIDTH  = 8,
   parameter int REG_ADDR_W = 3
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            in_op;
   logic [REG_ADDR_W-1:0] in_rd;
   logic [REG_ADDR_W-1:0] in_ra;
   logic [REG_ADDR_W-1:0] in_rb;
   logic [BUS_WIDTH-1:0]  in_imm;

   logic                  wb_en;
   logic                  wb_ready;
   logic [REG_ADDR_W-1:0] wb_addr;
   logic [BUS_WIDTH-1:0]  wb_data;

   modport slave (
      input  in_valid, in_op, in_rd, in_ra, in_rb, in_imm, wb_ready,
      output in_ready, wb_en, wb_addr, wb_data
   );

   modport master (
      output in_valid, in_op, in_rd, in_ra, in_rb, in_imm, wb_ready,
      input  in_ready, wb_en, wb_addr, wb_data
   );

endinterface

// File: rtl/alu_issue_seq.sv
// Non-pipelined issue/writeback sequencer in front of the ALU (IDLE->READ->EXEC->WB).
// Optional zero/negative result flags are built when ALU_ISSUE_SEQ_FLAGS_EN is defined.
module alu_issue_seq
   import alu_issue_pkg::*;
#(
   parameter int BUS_WIDTH  = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_issue_seq_if.slave        bus,
   output logic [REG_ADDR_W-1:0] ra_addr,
   output logic [REG_ADDR_W-1:0] rb_addr,
   output logic [BUS_WIDTH-1:0]  alu_imm,
   output logic [4:0]            alu_reg_en,
   output logic                  alu_f_add,
   output logic                  alu_f_load,
   input  logic [BUS_WIDTH-1:0]  alu_result,
   output logic                  busy
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
   ,
   output logic                  flag_z,
   output logic                  flag_n
`endif
);

   state_t                state_q, state_d;
   op_t                   op_q, op_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic [REG_ADDR_W-1:0] ra_q, ra_d;
   logic [REG_ADDR_W-1:0] rb_q, rb_d;
   logic [BUS_WIDTH-1:0]  imm_q, imm_d;
   logic [BUS_WIDTH-1:0]  res_q, res_d;
   logic                  in_ready_c;
   logic                  wb_en_c;
   logic                  take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         rd_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         imm_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         imm_q   <= imm_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rd_d       = rd_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      imm_d      = imm_q;
      res_d      = res_q;
      in_ready_c = 1'b0;
      wb_en_c    = 1'b0;
      alu_reg_en = REG_EN_NONE;
      alu_f_add  = 1'b0;
      alu_f_load = 1'b0;
      take       = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            take       = bus.in_valid;
         end
         READ: begin
            alu_reg_en = REG_EN_ALL;
            alu_f_add  = (op_q == OP_ADD);
            alu_f_load = (op_q == OP_LOAD);
            state_d    = EXEC;
         end
         EXEC: begin
            alu_f_add  = (op_q == OP_ADD);
            alu_f_load = (op_q == OP_LOAD);
            res_d      = alu_result;
            state_d    = WB;
         end
         WB: begin
            wb_en_c    = 1'b1;
            in_ready_c = bus.wb_ready;
            if (bus.wb_ready) begin
               take    = bus.in_valid;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // An accepted NOP is simply dropped, so it never costs a cycle.
      if (take && (op_t'(bus.in_op) != OP_NOP)) begin
         op_d    = op_t'(bus.in_op);
         rd_d    = bus.in_rd;
         ra_d    = bus.in_ra;
         rb_d    = bus.in_rb;
         imm_d   = bus.in_imm;
         state_d = READ;
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.wb_en    = wb_en_c;
   assign bus.wb_addr  = rd_q;
   assign bus.wb_data  = res_q;
   assign ra_addr      = ra_q;
   assign rb_addr      = rb_q;
   assign alu_imm      = imm_q;
   assign busy         = (state_q != IDLE);

`ifdef ALU_ISSUE_SEQ_FLAGS_EN
   logic flag_z_q, flag_z_d;
   logic flag_n_q, flag_n_d;

   always_comb begin
      flag_z_d = flag_z_q;
      flag_n_d = flag_n_q;
      if (wb_en_c && bus.wb_ready) begin
         flag_z_d = (res_q == '0);
         flag_n_d = res_q[BUS_WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
      end else begin
         flag_z_q <= flag_z_d;
         flag_n_q <= flag_n_d;
      end
   end

   assign flag_z = flag_z_q;
   assign flag_n = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed self-checking bench for alu_issue_seq with a small register file and ALU model.
// Flag checks are compiled in when ALU_ISSUE_SEQ_FLAGS_EN is defined.
module tb_alu_issue_seq;
   import alu_issue_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] ra_addr, rb_addr;
   logic [7:0] alu_imm;
   logic [4:0] alu_reg_en;
   logic       alu_f_add, alu_f_load;
   logic [7:0] alu_result;
   logic       busy;
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
   logic       flag_z, flag_n;
`endif

   int checks   = 0;
   int failures = 0;
   int write_cnt = 0;

   alu_issue_seq_if #(.BUS_WIDTH(8), .REG_ADDR_W(3)) bus ();

   alu_issue_seq #(.BUS_WIDTH(8), .REG_ADDR_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .ra_addr    (ra_addr),
      .rb_addr    (rb_addr),
      .alu_imm    (alu_imm),
      .alu_reg_en (alu_reg_en),
      .alu_f_add  (alu_f_add),
      .alu_f_load (alu_f_load),
      .alu_result (alu_result),
      .busy       (busy)
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
      ,
      .flag_z     (flag_z),
      .flag_n     (flag_n)
`endif
   );

   always #5 clk = ~clk;

   // Register file: combinational read, write on the accepted writeback edge
   logic [7:0] regs [0:7] = '{8'h00, 8'h17, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};

   always @(posedge clk) begin
      if (bus.wb_en && bus.wb_ready) begin
         regs[bus.wb_addr] <= bus.wb_data;
         write_cnt         <= write_cnt + 1;
      end
   end

   // ALU model: operand registers load on reg_en, result is combinational from them
   logic [7:0] op_a, op_b, op_imm;
   logic       op_add, op_load;

   always @(posedge clk) begin
      if (alu_reg_en == 5'h1F) begin
         op_a    <= regs[ra_addr];
         op_b    <= regs[rb_addr];
         op_imm  <= alu_imm;
         op_add  <= alu_f_add;
         op_load <= alu_f_load;
      end
   end

   always_comb begin
      alu_result = 8'h00;
      if (op_load)     alu_result = op_imm;
      else if (op_add) alu_result = op_a + op_b;
      else             alu_result = op_a * op_imm + op_b;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_instr(input logic [1:0] op, input logic [2:0] rd,
                              input logic [2:0] ra, input logic [2:0] rb,
                              input logic [7:0] imm);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_rd    = rd;
      bus.in_ra    = ra;
      bus.in_rb    = rb;
      bus.in_imm   = imm;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_op    = 2'd3;
      bus.in_rd    = '0;
      bus.in_ra    = '0;
      bus.in_rb    = '0;
      bus.in_imm   = '0;
      bus.wb_ready = 1'b1;
      tick();
      tick();
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL rst_wb_en got=%b exp=0", bus.wb_en); end
      checks++; if (alu_reg_en !== 5'h00) begin failures++; $display("FAIL rst_reg_en got=%h exp=00", alu_reg_en); end
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
      checks++; if ({flag_z, flag_n} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {flag_z, flag_n}); end
`endif
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.wb_en !== 1'b0 || alu_reg_en !== 5'h00) begin
            failures++;
            $display("FAIL idle_hold cyc=%0d got rdy=%b busy=%b wb_en=%b reg_en=%h exp 1/0/0/00",
                     i, bus.in_ready, busy, bus.wb_en, alu_reg_en);
         end
      end
   endtask

   task automatic test_add();
      drive_instr(2'd0, 3'd2, 3'd1, 3'd3, 8'h05);
      tick();
      bus.in_valid = 1'b0;
      checks++; if ({ra_addr, rb_addr} !== {3'd1, 3'd3}) begin failures++; $display("FAIL add_read_addr got=%0d,%0d exp=1,3", ra_addr, rb_addr); end
      checks++; if (alu_reg_en !== 5'h1F) begin failures++; $display("FAIL add_reg_en got=%h exp=1f", alu_reg_en); end
      checks++; if ({alu_f_add, alu_f_load} !== 2'b10) begin failures++; $display("FAIL add_flags_read got=%b exp=10", {alu_f_add, alu_f_load}); end
      checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL add_busy got=%b,%b exp=1,0", busy, bus.in_ready); end
      tick();
      checks++; if (alu_reg_en !== 5'h00 || alu_f_add !== 1'b1 || alu_imm !== 8'h05) begin
         failures++; $display("FAIL add_exec got reg_en=%h f_add=%b imm=%h exp 00/1/05", alu_reg_en, alu_f_add, alu_imm); end
      checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL add_exec_wb_en got=%b exp=0", bus.wb_en); end
      tick();
      checks++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 3'd2 || bus.wb_data !== 8'h2A) begin
         failures++; $display("FAIL add_wb got en=%b addr=%0d data=%h exp 1/2/2a", bus.wb_en, bus.wb_addr, bus.wb_data); end
      tick();
      checks++; if (bus.wb_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL add_done got en=%b busy=%b exp 0/0", bus.wb_en, busy); end
      checks++; if (regs[2] !== 8'h2A || write_cnt !== 1) begin failures++; $display("FAIL add_write got r2=%h writes=%0d exp 2a/1", regs[2], write_cnt); end
   endtask

   task automatic test_mac();
      drive_instr(2'd1, 3'd0, 3'd1, 3'd3, 8'h02);
      tick();
      bus.in_valid = 1'b0;
      checks++; if ({alu_f_add, alu_f_load, alu_reg_en} !== {2'b00, 5'h1F}) begin
         failures++; $display("FAIL mac_read got add=%b load=%b reg_en=%h exp 0/0/1f", alu_f_add, alu_f_load, alu_reg_en); end
      tick();
      tick();
      checks++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 3'd0 || bus.wb_data !== 8'h41) begin
         failures++; $display("FAIL mac_wb got en=%b addr=%0d data=%h exp 1/0/41", bus.wb_en, bus.wb_addr, bus.wb_data); end
      tick();
   endtask

   task automatic test_load_backpressure();
      int base;
      base = write_cnt;
      bus.wb_ready = 1'b0;
      drive_instr(2'd2, 3'd7, 3'd0, 3'd0, 8'h80);
      tick();
      bus.in_valid = 1'b0;
      checks++; if ({alu_f_load, alu_f_add} !== 2'b10 || alu_imm !== 8'h80) begin
         failures++; $display("FAIL load_read got load=%b add=%b imm=%h exp 1/0/80", alu_f_load, alu_f_add, alu_imm); end
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.wb_en !== 1'b1 || bus.wb_addr !== 3'd7 || bus.wb_data !== 8'h80 ||
             bus.in_ready !== 1'b0 || write_cnt !== base) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got en=%b addr=%0d data=%h rdy=%b writes=%0d exp 1/7/80/0/%0d",
                     i, bus.wb_en, bus.wb_addr, bus.wb_data, bus.in_ready, write_cnt, base);
         end
         tick();
      end
      bus.wb_ready = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready got=%b exp=1", bus.in_ready); end
      tick();
      checks++; if (write_cnt !== base + 1 || regs[7] !== 8'h80 || bus.wb_en !== 1'b0) begin
         failures++; $display("FAIL bp_release got writes=%0d r7=%h en=%b exp %0d/80/0", write_cnt, regs[7], bus.wb_en, base + 1); end
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
      checks++; if ({flag_z, flag_n} !== 2'b01) begin failures++; $display("FAIL load_flags got z,n=%b exp=01", {flag_z, flag_n}); end
`endif
   endtask

   task automatic test_back_to_back();
      int base;
      base = write_cnt;
      drive_instr(2'd0, 3'd5, 3'd2, 3'd1, 8'h00);
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      drive_instr(2'd0, 3'd6, 3'd5, 3'd5, 8'h00);
      #1;
      checks++; if (bus.in_ready !== 1'b1 || bus.wb_data !== 8'h41 || bus.wb_addr !== 3'd5) begin
         failures++; $display("FAIL b2b_wb1 got rdy=%b addr=%0d data=%h exp 1/5/41", bus.in_ready, bus.wb_addr, bus.wb_data); end
      tick();
      bus.in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || alu_reg_en !== 5'h1F || ra_addr !== 3'd5 || bus.wb_en !== 1'b0) begin
         failures++; $display("FAIL b2b_read2 got busy=%b reg_en=%h ra=%0d en=%b exp 1/1f/5/0", busy, alu_reg_en, ra_addr, bus.wb_en); end
      checks++; if (regs[5] !== 8'h41) begin failures++; $display("FAIL b2b_raw got r5=%h exp=41", regs[5]); end
      tick();
      tick();
      drive_instr(2'd3, 3'd1, 3'd1, 3'd1, 8'h00);
      #1;
      checks++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 3'd6 || bus.wb_data !== 8'h82) begin
         failures++; $display("FAIL b2b_wb2 got en=%b addr=%0d data=%h exp 1/6/82", bus.wb_en, bus.wb_addr, bus.wb_data); end
      tick();
      bus.in_valid = 1'b0;
      checks++; if (busy !== 1'b0 || write_cnt !== base + 2) begin
         failures++; $display("FAIL b2b_nop_idle got busy=%b writes=%0d exp 0/%0d", busy, write_cnt, base + 2); end
      drive_instr(2'd3, 3'd2, 3'd2, 3'd2, 8'h00);
      tick();
      drive_instr(2'd0, 3'd4, 3'd6, 3'd7, 8'h00);
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL nop_discard got busy=%b rdy=%b exp 0/1", busy, bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || ra_addr !== 3'd6 || rb_addr !== 3'd7) begin
         failures++; $display("FAIL after_nop_read got busy=%b ra=%0d rb=%0d exp 1/6/7", busy, ra_addr, rb_addr); end
      tick();
      tick();
      checks++; if (bus.wb_data !== 8'h02 || bus.wb_addr !== 3'd4) begin
         failures++; $display("FAIL trunc_wb got addr=%0d data=%h exp 4/02", bus.wb_addr, bus.wb_data); end
      tick();
      checks++; if (write_cnt !== base + 3 || regs[4] !== 8'h02) begin
         failures++; $display("FAIL trunc_write got writes=%0d r4=%h exp %0d/02", write_cnt, regs[4], base + 3); end
`ifdef ALU_ISSUE_SEQ_FLAGS_EN
      checks++; if ({flag_z, flag_n} !== 2'b00) begin failures++; $display("FAIL trunc_flags got z,n=%b exp=00", {flag_z, flag_n}); end
`endif
   endtask

   task automatic test_reset_mid_exec();
      int  base;
      logic saw_wb;
      base   = write_cnt;
      saw_wb = 1'b0;
      drive_instr(2'd0, 3'd1, 3'd2, 3'd2, 8'h00);
      tick();
      bus.in_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.wb_en !== 1'b0 || alu_reg_en !== 5'h00) begin
         failures++; $display("FAIL async_rst got busy=%b rdy=%b en=%b reg_en=%h exp 0/1/0/00", busy, bus.in_ready, bus.wb_en, alu_reg_en); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (bus.wb_en === 1'b1) saw_wb = 1'b1;
         tick();
      end
      checks++; if (saw_wb !== 1'b0 || write_cnt !== base || regs[1] !== 8'h17) begin
         failures++; $display("FAIL rst_drop got saw_wb=%b writes=%0d r1=%h exp 0/%0d/17", saw_wb, write_cnt, regs[1], base); end
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL rst_idle got busy=%b rdy=%b exp 0/1", busy, bus.in_ready); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mac();
      test_load_backpressure();
      test_back_to_back();
      test_reset_mid_exec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
